gb_cpu_regfile_banked: RTL and testbench

//  Parametrised successor to the CPU register file: NUM_REGS 8-bit registers, pairable as 16-bit (even=hi, odd=lo).
//  N prioritised write ports, M read ports, shadow bank with multi-cycle save/restore FSM (interrupt context).

---
 rtl/gb_cpu_regfile_banked_if.sv | 32 +++
 rtl/gb_cpu_regfile_banked.sv | 130 +++++++++++++
 tb/tb_gb_cpu_regfile_banked.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gb_cpu_regfile_banked_if.sv
// Register-file port bundle: write ports, read ports and shadow-bank save/restore control.
// The core side drives through master; the register file takes slave.
interface gb_cpu_regfile_banked_if #(
  parameter int NUM_REGS = 16,
  parameter int W_PORTS  = 4,
  parameter int R_PORTS  = 3
);
  localparam int IDX_W = $clog2(NUM_REGS);

  logic [W_PORTS-1:0]            wr_en;
  logic [W_PORTS-1:0]            wr_pair;
  logic [W_PORTS-1:0][IDX_W-1:0] wr_sel;
  logic [W_PORTS-1:0][15:0]      wr_data;
  logic                          wr_stall;
  logic [R_PORTS-1:0]            rd_pair;
  logic [R_PORTS-1:0][IDX_W-1:0] rd_sel;
  logic [R_PORTS-1:0][15:0]      rd_data;
  logic                          save_req;
  logic                          restore_req;
  logic                          busy;
  logic                          done;

  modport master (
    output wr_en, wr_pair, wr_sel, wr_data, rd_pair, rd_sel, save_req, restore_req,
    input  wr_stall, rd_data, busy, done
  );

  modport slave (
    input  wr_en, wr_pair, wr_sel, wr_data, rd_pair, rd_sel, save_req, restore_req,
    output wr_stall, rd_data, busy, done
  );
endinterface

// File: rtl/gb_cpu_regfile_banked.sv
// Banked CPU register file: byte/pair access, prioritised write ports, shadow bank save/restore FSM.
// Optional GB_CPU_REGFILE_BYPASS_EN forwards same-cycle winning write bytes onto the read ports.
module gb_cpu_regfile_banked #(
  parameter int NUM_REGS       = 16,
  parameter int W_PORTS        = 4,
  parameter int R_PORTS        = 3,
  parameter int COPY_PER_CYCLE = 4,
  parameter logic [NUM_REGS*8-1:0] INIT_VEC = '0
) (
  input logic clk,
  input logic reset,
  gb_cpu_regfile_banked_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int BEATS = NUM_REGS / COPY_PER_CYCLE;
  localparam logic [IDX_W:0]   NREGS = (IDX_W+1)'(NUM_REGS);
  localparam logic [IDX_W-1:0] STEP  = IDX_W'(COPY_PER_CYCLE);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_REGS - COPY_PER_CYCLE);
  localparam logic [IDX_W-1:0] ONE   = IDX_W'(1);

  typedef enum logic [1:0] {IDLE, SAVE, RESTORE} state_t;

  state_t                       state;
  logic [IDX_W-1:0]             ptr;
  logic [7:0]                   live   [NUM_REGS];
  logic [7:0]                   shadow [NUM_REGS];
  logic                         busy_q, done_q, stall_q;
  logic [NUM_REGS-1:0]          wmask;
  logic [NUM_REGS-1:0][7:0]     wval;
  logic [NUM_REGS-1:0][7:0]     view;
  logic [W_PORTS-1:0][IDX_W-1:0] w_hi, w_lo;
  logic [W_PORTS-1:0]           w_ok;

  for (genvar p = 0; p < W_PORTS; p++) begin : g_wr
    assign w_hi[p] = bus.wr_sel[p] & ~ONE;
    assign w_lo[p] = w_hi[p] | ONE;
    assign w_ok[p] = bus.wr_en[p] && !stall_q &&
                     ({1'b0, (bus.wr_pair[p] ? w_hi[p] : bus.wr_sel[p])} < NREGS);
  end

  // Highest index first so port 0 overwrites last and wins each byte it touches.
  always_comb begin
    wmask = '0;
    wval  = '0;
    for (int p = W_PORTS-1; p >= 0; p--) begin
      if (w_ok[p]) begin
        if (bus.wr_pair[p]) begin
          wmask[w_hi[p]] = 1'b1;
          wval[w_hi[p]]  = bus.wr_data[p][15:8];
          wmask[w_lo[p]] = 1'b1;
          wval[w_lo[p]]  = bus.wr_data[p][7:0];
        end else begin
          wmask[bus.wr_sel[p]] = 1'b1;
          wval[bus.wr_sel[p]]  = bus.wr_data[p][7:0];
        end
      end
    end
  end

  always_comb begin
    view = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      view[i] = live[i];
`ifdef GB_CPU_REGFILE_BYPASS_EN
      if (wmask[i]) view[i] = wval[i];
`endif
    end
  end

  for (genvar r = 0; r < R_PORTS; r++) begin : g_rd
    logic [IDX_W-1:0] hi, lo;
    assign hi = bus.rd_sel[r] & ~ONE;
    assign lo = hi | ONE;
    assign bus.rd_data[r] = ({1'b0, bus.rd_sel[r]} >= NREGS) ? 16'h0000 :
                            bus.rd_pair[r] ? {view[hi], view[lo]} :
                                             {8'h00, view[bus.rd_sel[r]]};
  end

  // done is registered one beat early so it is high during the final copy beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        live[i]   <= INIT_VEC[8*i +: 8];
        shadow[i] <= 8'h00;
      end
      state   <= IDLE;
      ptr     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (wmask[i]) live[i] <= wval[i];
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.save_req) begin
            state  <= SAVE;
            busy_q <= 1'b1;
            done_q <= (BEATS == 1);
          end else if (bus.restore_req) begin
            state   <= RESTORE;
            busy_q  <= 1'b1;
            stall_q <= 1'b1;
            done_q  <= (BEATS == 1);
          end
        end
        default: begin
          for (int k = 0; k < COPY_PER_CYCLE; k++) begin
            if (state == SAVE) shadow[ptr + IDX_W'(k)] <= live[ptr + IDX_W'(k)];
            else               live[ptr + IDX_W'(k)]   <= shadow[ptr + IDX_W'(k)];
          end
          if (ptr == LAST) begin
            state   <= IDLE;
            ptr     <= '0;
            busy_q  <= 1'b0;
            stall_q <= 1'b0;
          end else begin
            ptr    <= ptr + STEP;
            done_q <= (ptr + STEP == LAST);
          end
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.wr_stall = stall_q;
endmodule

// File: tb/tb_gb_cpu_regfile_banked.sv
// Scoreboarded bench for gb_cpu_regfile_banked: 12 regs, 4 write / 3 read ports, 3 regs per copy beat.
module tb_gb_cpu_regfile_banked;
  localparam int NR = 12;
  localparam int WP = 4;
  localparam int RP = 3;
  localparam int CP = 3;
  localparam int IW = $clog2(NR);
  localparam logic [NR*8-1:0] INIT = 96'h1B1A_1918_1716_1514_1312_B001;

  typedef struct {
    int          port;
    logic [15:0] exp;
    string       name;
  } rd_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  rd_t  sb[$];

  always #5 clk = ~clk;

  gb_cpu_regfile_banked_if #(.NUM_REGS(NR), .W_PORTS(WP), .R_PORTS(RP)) bus ();

  gb_cpu_regfile_banked #(
    .NUM_REGS(NR), .W_PORTS(WP), .R_PORTS(RP), .COPY_PER_CYCLE(CP), .INIT_VEC(INIT)
  ) u_dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_wr();
    bus.wr_en   = '0;
    bus.wr_pair = '0;
    bus.wr_sel  = '0;
    bus.wr_data = '0;
  endtask

  task automatic drive_wr(input int p, input logic pair, input logic [IW-1:0] sel,
                          input logic [15:0] data);
    bus.wr_en[p]   = 1'b1;
    bus.wr_pair[p] = pair;
    bus.wr_sel[p]  = sel;
    bus.wr_data[p] = data;
  endtask

  task automatic issue_rd(input int p, input logic pair, input logic [IW-1:0] sel,
                          input logic [15:0] exp, input string name);
    rd_t e;
    bus.rd_pair[p] = pair;
    bus.rd_sel[p]  = sel;
    e.port = p;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rd_t e;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    issue_rd(0, 1'b1, 4'd0,  16'h01B0, "rst_pair0");
    issue_rd(1, 1'b0, 4'd11, 16'h001B, "rst_byte11");
    issue_rd(2, 1'b1, 4'd5,  16'h1415, "rst_pair5");
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (bus.rd_data[e.port] !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h want %h", e.name, bus.rd_data[e.port], e.exp);
      end
    end
    checks++;
    if ({bus.busy, bus.done, bus.wr_stall} !== 3'b000) begin
      failures++;
      $display("FAIL rst_flags: got busy/done/stall=%b want 000", {bus.busy, bus.done, bus.wr_stall});
    end
  endtask

  task automatic test_priority();
    rd_t e;
    drive_wr(0, 1'b0, 4'd3, 16'h00AA);
    drive_wr(2, 1'b1, 4'd2, 16'h1234);
    drive_wr(1, 1'b1, 4'd6, 16'h6666);
    drive_wr(3, 1'b0, 4'd7, 16'h0077);
    issue_rd(0, 1'b1, 4'd2, 16'h12AA, "prio_pair2");
    issue_rd(1, 1'b1, 4'd7, 16'h6666, "prio_pair6");
    issue_rd(2, 1'b0, 4'd3, 16'h00AA, "prio_byte3");
    tick();
    clear_wr();
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (bus.rd_data[e.port] !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h want %h", e.name, bus.rd_data[e.port], e.exp);
      end
    end
  endtask

  task automatic test_pair_range();
    rd_t e;
    drive_wr(0, 1'b1, 4'd5,  16'hBEEF);
    drive_wr(1, 1'b0, 4'd12, 16'h0099);
    drive_wr(2, 1'b1, 4'd13, 16'h4242);
    tick();
    clear_wr();
    issue_rd(0, 1'b1, 4'd4,  16'hBEEF, "align_pair4");
    issue_rd(1, 1'b0, 4'd5,  16'h00EF, "align_byte5");
    issue_rd(2, 1'b0, 4'd12, 16'h0000, "range_byte12");
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (bus.rd_data[e.port] !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h want %h", e.name, bus.rd_data[e.port], e.exp);
      end
    end
    issue_rd(0, 1'b1, 4'd13, 16'h0000, "range_pair13");
    issue_rd(1, 1'b0, 4'd0,  16'h0001, "range_nowrap0");
    issue_rd(2, 1'b1, 4'd0,  16'h01B0, "range_nowrap_pair0");
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (bus.rd_data[e.port] !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h want %h", e.name, bus.rd_data[e.port], e.exp);
      end
    end
  endtask

  task automatic test_save_restore();
    rd_t e;
    int n, done_at;
    bus.save_req = 1'b1;
    tick();
    bus.save_req = 1'b0;
    n = 0;
    done_at = 0;
    while (bus.busy && n < 20) begin
      n++;
      if (bus.done) done_at = n;
      if (n == 1) drive_wr(1, 1'b0, 4'd0, 16'h0055);
      tick();
      clear_wr();
    end
    checks++;
    if (n !== 4 || done_at !== 4) begin
      failures++;
      $display("FAIL save_beats: got busy=%0d done_at=%0d want 4/4", n, done_at);
    end
    issue_rd(0, 1'b0, 4'd0, 16'h0055, "save_live_write");
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (bus.rd_data[e.port] !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h want %h", e.name, bus.rd_data[e.port], e.exp);
      end
    end
    bus.restore_req = 1'b1;
    tick();
    bus.restore_req = 1'b0;
    n = 0;
    done_at = 0;
    while (bus.busy && n < 20) begin
      n++;
      if (bus.done) done_at = n;
      tick();
    end
    checks++;
    if (n !== 4 || done_at !== 4) begin
      failures++;
      $display("FAIL restore_beats: got busy=%0d done_at=%0d want 4/4", n, done_at);
    end
    issue_rd(0, 1'b0, 4'd0, 16'h0001, "restore_reg0");
    issue_rd(1, 1'b1, 4'd2, 16'h12AA, "restore_pair2");
    issue_rd(2, 1'b1, 4'd4, 16'hBEEF, "restore_pair4");
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (bus.rd_data[e.port] !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h want %h", e.name, bus.rd_data[e.port], e.exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    bus.save_req    = 1'b1;
    bus.restore_req = 1'b1;
    tick();
    bus.save_req    = 1'b0;
    bus.restore_req = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.wr_stall !== 1'b0) begin
      failures++;
      $display("FAIL both_req_save: got busy=%b stall=%b want 1/0", bus.busy, bus.wr_stall);
    end
    n = 0;
    while (bus.busy && n < 20) begin
      n++;
      bus.restore_req = (n == 2);
      tick();
    end
    bus.restore_req = 1'b0;
    tick();
    checks++;
    if (n !== 4 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL midop_req_ignored: got beats=%0d busy_after=%b want 4/0", n, bus.busy);
    end
  endtask

  task automatic test_restore_stall();
    rd_t e;
    int n, nostall;
    drive_wr(0, 1'b0, 4'd9, 16'h0099);
    tick();
    clear_wr();
    bus.restore_req = 1'b1;
    tick();
    bus.restore_req = 1'b0;
    n = 0;
    nostall = 0;
    while (bus.busy && n < 20) begin
      n++;
      if (bus.wr_stall !== 1'b1) nostall++;
      for (int p = 0; p < WP; p++) drive_wr(p, 1'b0, 4'd10, 16'h00F0 + 16'(p));
      bus.save_req = (n == 2);
      tick();
    end
    clear_wr();
    bus.save_req = 1'b0;
    checks++;
    if (n !== 4 || nostall !== 0) begin
      failures++;
      $display("FAIL restore_stall: got beats=%0d unstalled=%0d want 4/0", n, nostall);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL restore_save_ignored: got busy=%b want 0", bus.busy);
    end
    issue_rd(0, 1'b0, 4'd10, 16'h001A, "stall_drop10");
    issue_rd(1, 1'b0, 4'd9,  16'h0019, "restore_reg9");
    issue_rd(2, 1'b0, 4'd0,  16'h0001, "restore_keep0");
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (bus.rd_data[e.port] !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h want %h", e.name, bus.rd_data[e.port], e.exp);
      end
    end
  endtask

  task automatic test_reset_mid_save();
    rd_t e;
    int n;
    drive_wr(0, 1'b0, 4'd0, 16'h0077);
    tick();
    clear_wr();
    bus.save_req = 1'b1;
    tick();
    bus.save_req = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL midsave_reset_flags: got busy=%b done=%b want 0/0", bus.busy, bus.done);
    end
    issue_rd(0, 1'b0, 4'd0, 16'h0001, "midsave_live0");
    issue_rd(1, 1'b1, 4'd8, 16'h1819, "midsave_live8");
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (bus.rd_data[e.port] !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h want %h", e.name, bus.rd_data[e.port], e.exp);
      end
    end
    bus.restore_req = 1'b1;
    tick();
    bus.restore_req = 1'b0;
    n = 0;
    while (bus.busy && n < 20) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 4) begin
      failures++;
      $display("FAIL midsave_restore_beats: got %0d want 4", n);
    end
    issue_rd(0, 1'b1, 4'd0,  16'h0000, "shadow_clr0");
    issue_rd(1, 1'b0, 4'd11, 16'h0000, "shadow_clr11");
    issue_rd(2, 1'b1, 4'd4,  16'h0000, "shadow_clr4");
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (bus.rd_data[e.port] !== e.exp) begin
        failures++;
        $display("FAIL %s: got %h want %h", e.name, bus.rd_data[e.port], e.exp);
      end
    end
  endtask

  initial begin
    reset           = 1'b1;
    bus.save_req    = 1'b0;
    bus.restore_req = 1'b0;
    bus.rd_pair     = '0;
    bus.rd_sel      = '0;
    clear_wr();
    test_reset();
    test_priority();
    test_pair_range();
    test_save_restore();
    test_back_to_back();
    test_restore_stall();
    test_reset_mid_save();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
